// File: rtl/vpu_tile_sequencer.sv
// Multi-tile FSM sequencer for the vector/systolic matmul datapath strobes.
// Optional cycle counter output enabled by defining VPU_SEQ_PERF_EN.
module vpu_tile_sequencer #(
  parameter int unsigned ROW_A     = 4,
  parameter int unsigned COL_A     = 4,
  parameter int unsigned ROW_W     = 4,
  parameter int unsigned N_KTILES  = 2,
  parameter int unsigned DRAIN_LAT = $clog2(ROW_A) + 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CNT_W-1:0]              n_tiles,
  output logic                          busy,
  output logic                          done,
  output logic                          compute,
  output logic                          load_a,
  output logic                          load_w,
  output logic                          deload,
  output logic                          store,
  output logic                          deload_out,
  output logic                          reset_sys,
  output logic [CNT_W-1:0]              tile_idx,
  output logic [$clog2(N_KTILES+1)-1:0] k_idx
`ifdef VPU_SEQ_PERF_EN
  ,
  output logic [31:0]                   perf_cycles
`endif
);

  localparam int unsigned KW     = $clog2(N_KTILES + 1);
  localparam int unsigned PH_MAX = COL_A + ROW_W + ROW_A * ROW_A + DRAIN_LAT + ROW_A;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_COMP = 4'd1;
  localparam logic [3:0] S_LDA  = 4'd2;
  localparam logic [3:0] S_LDW  = 4'd3;
  localparam logic [3:0] S_GAP  = 4'd4;
  localparam logic [3:0] S_DEL  = 4'd5;
  localparam logic [3:0] S_DRN  = 4'd6;
  localparam logic [3:0] S_OUT  = 4'd7;
  localparam logic [3:0] S_RST  = 4'd8;

  logic [3:0]           state, state_d;
  logic [PH_W-1:0]      phase, phase_d;
  logic [CNT_W-1:0]     ntiles_q, ntiles_d;
  logic [CNT_W-1:0]     tile_d;
  logic [KW-1:0]        k_d;
  logic                 done_d;
  logic                 last;
  logic [DRAIN_LAT-1:0] store_sr;

  assign last = (phase == '0);

  // Phase counter is loaded with (length-1) on each entry and counts down to 0.
  always_comb begin
    state_d  = state;
    phase_d  = phase;
    ntiles_d = ntiles_q;
    tile_d   = tile_idx;
    k_d      = k_idx;
    done_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          ntiles_d = n_tiles;
          if (n_tiles == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_COMP;
            phase_d = '0;
            tile_d  = '0;
            k_d     = '0;
          end
        end
      end
      S_COMP: begin
        state_d = S_LDA;
        phase_d = PH_W'(COL_A - 1);
      end
      S_LDA: begin
        if (last) begin
          state_d = S_LDW;
          phase_d = PH_W'(ROW_W - 1);
        end else begin
          phase_d = phase - 1'b1;
        end
      end
      S_LDW: begin
        if (last) begin
          state_d = S_GAP;
          phase_d = '0;
        end else begin
          phase_d = phase - 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_DEL;
        phase_d = PH_W'(ROW_A * ROW_A - 1);
      end
      S_DEL: begin
        if (last) begin
          state_d = S_DRN;
          phase_d = PH_W'(DRAIN_LAT - 1);
        end else begin
          phase_d = phase - 1'b1;
        end
      end
      S_DRN: begin
        if (last) begin
          if (k_idx != KW'(N_KTILES - 1)) begin
            k_d     = k_idx + 1'b1;
            state_d = S_COMP;
            phase_d = '0;
          end else begin
            state_d = S_OUT;
            phase_d = PH_W'(ROW_A - 1);
          end
        end else begin
          phase_d = phase - 1'b1;
        end
      end
      S_OUT: begin
        if (last) begin
          state_d = S_RST;
          phase_d = '0;
        end else begin
          phase_d = phase - 1'b1;
        end
      end
      S_RST: begin
        if (tile_idx != ntiles_q - 1'b1) begin
          tile_d  = tile_idx + 1'b1;
          k_d     = '0;
          state_d = S_COMP;
          phase_d = '0;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so each one tracks its state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= '0;
      ntiles_q   <= '0;
      tile_idx   <= '0;
      k_idx      <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      compute    <= 1'b0;
      load_a     <= 1'b0;
      load_w     <= 1'b0;
      deload     <= 1'b0;
      deload_out <= 1'b0;
      reset_sys  <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      ntiles_q   <= ntiles_d;
      tile_idx   <= tile_d;
      k_idx      <= k_d;
      done       <= done_d;
      busy       <= (state_d != S_IDLE);
      compute    <= (state_d == S_COMP);
      load_a     <= (state_d == S_LDA);
      load_w     <= (state_d == S_LDW);
      deload     <= (state_d == S_DEL);
      deload_out <= (state_d == S_OUT);
      reset_sys  <= (state_d == S_RST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_sr <= '0;
    end else begin
      store_sr <= DRAIN_LAT'({store_sr, deload});
    end
  end

  assign store = store_sr[DRAIN_LAT-1];

`ifdef VPU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vpu_tile_sequencer.sv
// Bench for vpu_tile_sequencer: job table plus hand sequences, scoreboard of
// per-cycle expected strobes derived from the job timing formulas.
module tb_vpu_tile_sequencer;

  localparam int ROW_A    = 4;
  localparam int COL_A    = 4;
  localparam int ROW_W    = 4;
  localparam int N_KTILES = 2;
  localparam int DL       = 5;
  localparam int CNT_W    = 16;
  localparam int SLICE    = 1 + COL_A + ROW_W + 1 + ROW_A * ROW_A + DL;
  localparam int TILE     = N_KTILES * SLICE + ROW_A + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] n_tiles;
  logic             busy, done, compute, load_a, load_w, deload, store, deload_out, reset_sys;
  logic [CNT_W-1:0] tile_idx;
  logic [1:0]       k_idx;
`ifdef VPU_SEQ_PERF_EN
  logic [31:0]      perf_cycles;
`endif

  int checks = 0;
  int errors = 0;

  vpu_tile_sequencer #(
    .ROW_A(ROW_A), .COL_A(COL_A), .ROW_W(ROW_W), .N_KTILES(N_KTILES),
    .DRAIN_LAT(DL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .n_tiles(n_tiles),
    .busy(busy), .done(done), .compute(compute), .load_a(load_a), .load_w(load_w),
    .deload(deload), .store(store), .deload_out(deload_out), .reset_sys(reset_sys),
    .tile_idx(tile_idx), .k_idx(k_idx)
`ifdef VPU_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [8:0] vec;
    int         tile;
    int         k;
    bit         idx_valid;
  } exp_t;

  typedef struct {
    int n;
    int exp_done;
  } job_t;

  exp_t sbq[$];
  job_t tbl[4];

  function automatic logic [8:0] dut_vec();
    return {busy, done, compute, load_a, load_w, deload, store, deload_out, reset_sys};
  endfunction

  // Bit order: busy, done, compute, load_a, load_w, deload, store, deload_out, reset_sys
  function automatic exp_t model(int t, int n);
    exp_t e;
    int u, r, s;
    e.t = t; e.vec = '0; e.tile = 0; e.k = 0; e.idx_valid = 1'b0;
    if (n == 0) begin
      e.vec[7] = (t == 1);
      return e;
    end
    if (t >= 1 && t <= n * TILE) begin
      e.vec[8] = 1'b1;
      u = t - 1;
      r = u % TILE;
      e.tile = u / TILE;
      e.idx_valid = 1'b1;
      if (r < N_KTILES * SLICE) begin
        s = r % SLICE;
        e.k = r / SLICE;
        e.vec[6] = (s == 0);
        e.vec[5] = (s >= 1 && s <= COL_A);
        e.vec[4] = (s > COL_A && s <= COL_A + ROW_W);
        e.vec[3] = (s >= COL_A + ROW_W + 2 && s < COL_A + ROW_W + 2 + ROW_A * ROW_A);
        e.vec[2] = (s >= COL_A + ROW_W + 2 + DL && s < SLICE);
      end else begin
        e.k = N_KTILES - 1;
        e.vec[1] = (r < N_KTILES * SLICE + ROW_A);
        e.vec[0] = (r == TILE - 1);
      end
    end
    e.vec[7] = (t == n * TILE + 1);
    return e;
  endfunction

  task automatic check(input string name, input int t, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, got, exp);
    end
  endtask

  // Drives a start, then compares every cycle against the scoreboard.
  // hold keeps start high and disturbs n_tiles; stop_at>0 truncates the job.
  task automatic run_job(input int n, input bit hold, input int stop_at, input int exp_done);
    int len, last_t, got_done;
    exp_t e;
    len    = (n == 0) ? 1 : n * TILE + 1;
    last_t = hold ? len : len + 2;
    if (stop_at > 0 && stop_at < last_t) last_t = stop_at;
    for (int t = 1; t <= last_t; t++) sbq.push_back(model(t, n));
    start   = 1'b1;
    n_tiles = CNT_W'(n);
    @(posedge clk);
    got_done = -1;
    for (int t = 1; t <= last_t; t++) begin
      @(negedge clk);
      if (t == 1) begin
        if (hold) n_tiles = CNT_W'(5);
        else      start   = 1'b0;
      end
      e = sbq.pop_front();
      check("strobes", t, dut_vec(), e.vec);
      if (e.idx_valid) begin
        check("tile_idx", t, tile_idx, e.tile);
        check("k_idx", t, k_idx, e.k);
      end
      if (done && got_done < 0) got_done = t;
`ifdef VPU_SEQ_PERF_EN
      if (n > 0 && t >= len && stop_at == 0) check("perf_cycles", t, perf_cycles, n * TILE);
`endif
    end
    if (stop_at == 0) check("done_cycle", n, got_done, exp_done);
  endtask

  initial begin
    tbl[0] = '{n: 1, exp_done: 68};
    tbl[1] = '{n: 3, exp_done: 202};
    tbl[2] = '{n: 0, exp_done: 1};
    tbl[3] = '{n: 2, exp_done: 135};

    reset   = 1'b1;
    start   = 1'b0;
    n_tiles = '0;
    repeat (3) @(negedge clk);
    check("reset_strobes", 0, dut_vec(), 0);
    check("reset_tile_idx", 0, tile_idx, 0);
    check("reset_k_idx", 0, k_idx, 0);
`ifdef VPU_SEQ_PERF_EN
    check("reset_perf", 0, perf_cycles, 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    check("idle_strobes", 0, dut_vec(), 0);

    for (int i = 0; i < 4; i++) begin
      run_job(tbl[i].n, 1'b0, 0, tbl[i].exp_done);
    end

    // start held through a whole job: no re-trigger, back-to-back from done
    run_job(1, 1'b1, 0, 68);
    run_job(1, 1'b0, 0, 68);

    // reset during DEL aborts to idle values; next start begins at k 0
    run_job(1, 1'b0, 20, 0);
    check("pre_abort_deload", 20, deload, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_strobes", 21, dut_vec(), 0);
    check("abort_tile_idx", 21, tile_idx, 0);
    check("abort_k_idx", 21, k_idx, 0);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_store_cleared", 22, store, 0);
    end
    run_job(1, 1'b0, 0, 68);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
